// File: rtl/pc_seq_if.sv
// pc_seq_if: branch/decode/EX inputs and fetch/pipeline-control outputs of pc_sequencer
interface pc_seq_if #(parameter int CNT_W = 32);
  logic [31:0] pc_br;
  logic br_taken;
  logic dec_valid;
  logic [3:0] dec_opcode;
  logic [4:0] dec_src_a;
  logic [4:0] dec_src_b;
  logic ex_valid;
  logic [3:0] ex_opcode;
  logic [4:0] ex_rd;
  logic halt_req;
  logic [31:0] pc_out;
  logic fetch_valid;
  logic ifid_en;
  logic idex_bubble;
  logic br_commit;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] stall_cnt;
  modport slave (
    input pc_br, br_taken, dec_valid, dec_opcode, dec_src_a, dec_src_b, ex_valid, ex_opcode, ex_rd, halt_req,
    output pc_out, fetch_valid, ifid_en, idex_bubble, br_commit, branch_cnt, stall_cnt
  );
  modport master (
    output pc_br, br_taken, dec_valid, dec_opcode, dec_src_a, dec_src_b, ex_valid, ex_opcode, ex_rd, halt_req,
    input pc_out, fetch_valid, ifid_en, idex_bubble, br_commit, branch_cnt, stall_cnt
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC with decode-resolved branches (delay slot), flag/load-use stalls, halt and perf counters
module pc_sequencer #(
  parameter logic [31:0] PC_INIT = 32'h0,
  parameter int STALL_CYCLES = 1,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic reset,
  pc_seq_if.slave bus
);
  localparam int SW = STALL_CYCLES > 1 ? $clog2(STALL_CYCLES) : 1;
  localparam logic [3:0] OP_ADDS = 4'd2, OP_BLT = 4'd3, OP_LDUR = 4'd6, OP_SUBS = 4'd11;
  typedef enum logic [1:0] {INIT, RUN, STALL, HALT} state_t;
  state_t state;
  logic [SW-1:0] cnt;
  logic flag_haz, load_haz, hazard, go;
  always_comb begin
    flag_haz = bus.dec_valid & bus.dec_opcode == OP_BLT & bus.ex_valid &
               (bus.ex_opcode == OP_ADDS | bus.ex_opcode == OP_SUBS);
    load_haz = bus.dec_valid & bus.ex_valid & bus.ex_opcode == OP_LDUR & bus.ex_rd != 5'd31 &
               (bus.ex_rd == bus.dec_src_a | bus.ex_rd == bus.dec_src_b);
    hazard = state == RUN & (flag_haz | load_haz);
    go = state == RUN & ~hazard;
  end
  assign bus.ifid_en = go;
  assign bus.idex_bubble = ~go;
  assign bus.br_commit = go & bus.dec_valid & bus.br_taken;
  assign bus.fetch_valid = state == RUN | state == STALL;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
      cnt <= '0;
      bus.pc_out <= PC_INIT;
      bus.branch_cnt <= '0;
      bus.stall_cnt <= '0;
    end else begin
      if (hazard | state == STALL) bus.stall_cnt <= bus.stall_cnt + CNT_W'(~&bus.stall_cnt);
      if (bus.br_commit) bus.branch_cnt <= bus.branch_cnt + CNT_W'(~&bus.branch_cnt);
      if (go) bus.pc_out <= bus.br_commit ? bus.pc_br : bus.pc_out + 32'd4;
      case (state)
        INIT: state <= RUN;
        RUN: begin
          if (hazard && STALL_CYCLES > 1) begin
            state <= STALL;
            cnt <= SW'(STALL_CYCLES - 1);
          end else if (go && bus.halt_req) state <= HALT;
        end
        STALL: begin
          cnt <= cnt - SW'(1);
          if (cnt == SW'(1)) state <= RUN;
        end
        default: state <= HALT;
      endcase
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scoreboard bench for pc_sequencer with STALL_CYCLES=1 and STALL_CYCLES=3 instances
module tb_pc_sequencer;
  localparam logic [3:0] ADDI = 4'd1, ADDS = 4'd2, BLT = 4'd3, CBZ = 4'd5, LDUR = 4'd6, SUBS = 4'd11;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  pc_seq_if #(.CNT_W(32)) a ();
  pc_seq_if #(.CNT_W(32)) b ();
  pc_sequencer #(.PC_INIT(32'h0), .STALL_CYCLES(1), .CNT_W(32)) u1 (.clk(clk), .reset(reset), .bus(a));
  pc_sequencer #(.PC_INIT(32'h0), .STALL_CYCLES(3), .CNT_W(32)) u3 (.clk(clk), .reset(reset), .bus(b));
  assign b.pc_br = a.pc_br;
  assign b.br_taken = a.br_taken;
  assign b.dec_valid = a.dec_valid;
  assign b.dec_opcode = a.dec_opcode;
  assign b.dec_src_a = a.dec_src_a;
  assign b.dec_src_b = a.dec_src_b;
  assign b.ex_valid = a.ex_valid;
  assign b.ex_opcode = a.ex_opcode;
  assign b.ex_rd = a.ex_rd;
  assign b.halt_req = a.halt_req;
  typedef struct {
    int dut;
    logic [31:0] pc;
    logic fv, ie, bub, bc;
    logic [31:0] bn, sn;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int n = 0;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] e);
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask
  task automatic idle();
    a.pc_br = '0; a.br_taken = 0; a.dec_valid = 0; a.dec_opcode = '0; a.dec_src_a = '0;
    a.dec_src_b = '0; a.ex_valid = 0; a.ex_opcode = '0; a.ex_rd = '0; a.halt_req = 0;
  endtask
  task automatic br(logic [31:0] t);
    a.dec_valid = 1; a.br_taken = 1; a.pc_br = t;
  endtask
  task automatic flag(logic ev, logic [3:0] eop, logic tk, logic [31:0] t);
    a.dec_valid = 1; a.dec_opcode = BLT; a.ex_valid = ev; a.ex_opcode = eop; a.br_taken = tk; a.pc_br = t;
  endtask
  task automatic ldu(logic [4:0] sa, logic [4:0] sb, logic [4:0] rd);
    a.dec_valid = 1; a.dec_opcode = CBZ; a.dec_src_a = sa; a.dec_src_b = sb;
    a.ex_valid = 1; a.ex_opcode = LDUR; a.ex_rd = rd;
  endtask
  task automatic step(int dut, logic [31:0] pc, logic fv, logic ie, logic bub, logic bc, logic [31:0] bn, logic [31:0] sn);
    exp_t e;
    q.push_back('{dut, pc, fv, ie, bub, bc, bn, sn});
    @(negedge clk);
    e = q.pop_front();
    n++;
    if (e.dut == 1) begin
      chk($sformatf("s%0d u1 pc_out", n), a.pc_out, e.pc);
      chk($sformatf("s%0d u1 fetch_valid", n), 32'(a.fetch_valid), 32'(e.fv));
      chk($sformatf("s%0d u1 ifid_en", n), 32'(a.ifid_en), 32'(e.ie));
      chk($sformatf("s%0d u1 idex_bubble", n), 32'(a.idex_bubble), 32'(e.bub));
      chk($sformatf("s%0d u1 br_commit", n), 32'(a.br_commit), 32'(e.bc));
      chk($sformatf("s%0d u1 branch_cnt", n), a.branch_cnt, e.bn);
      chk($sformatf("s%0d u1 stall_cnt", n), a.stall_cnt, e.sn);
    end else begin
      chk($sformatf("s%0d u3 pc_out", n), b.pc_out, e.pc);
      chk($sformatf("s%0d u3 fetch_valid", n), 32'(b.fetch_valid), 32'(e.fv));
      chk($sformatf("s%0d u3 ifid_en", n), 32'(b.ifid_en), 32'(e.ie));
      chk($sformatf("s%0d u3 idex_bubble", n), 32'(b.idex_bubble), 32'(e.bub));
      chk($sformatf("s%0d u3 br_commit", n), 32'(b.br_commit), 32'(e.bc));
      chk($sformatf("s%0d u3 branch_cnt", n), b.branch_cnt, e.bn);
      chk($sformatf("s%0d u3 stall_cnt", n), b.stall_cnt, e.sn);
    end
    @(posedge clk);
    #1;
    idle();
  endtask
  task automatic run(int d, logic [31:0] pc, logic bc, logic [31:0] bn, logic [31:0] sn);
    step(d, pc, 1, 1, 0, bc, bn, sn);
  endtask
  task automatic stl(int d, logic [31:0] pc, logic [31:0] bn, logic [31:0] sn);
    step(d, pc, 1, 0, 1, 0, bn, sn);
  endtask
  task automatic hlt(int d, logic [31:0] pc, logic [31:0] bn, logic [31:0] sn);
    step(d, pc, 0, 0, 1, 0, bn, sn);
  endtask
  task automatic ini(int d);
    step(d, 32'h0, 0, 0, 1, 0, 0, 0);
  endtask
  task automatic do_reset();
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
  endtask
  initial begin
    idle();
    do_reset();
    ini(1);
    for (int i = 0; i < 8; i++) run(1, 32'(i * 4), 0, 0, 0);
    br(32'h100); run(1, 32'h20, 1, 0, 0);
    run(1, 32'h100, 0, 1, 0);
    flag(1, SUBS, 1, 32'h200); stl(1, 32'h104, 1, 0);
    flag(1, ADDI, 1, 32'h200); run(1, 32'h104, 1, 1, 1);
    run(1, 32'h200, 0, 2, 1);
    flag(1, ADDS, 0, 0); stl(1, 32'h204, 2, 1);
    run(1, 32'h204, 0, 2, 2);
    flag(0, SUBS, 0, 0); run(1, 32'h208, 0, 2, 2);
    ldu(0, 5, 5); stl(1, 32'h20C, 2, 2);
    run(1, 32'h20C, 0, 2, 3);
    ldu(31, 0, 31); run(1, 32'h210, 0, 2, 3);
    ldu(7, 0, 7); a.dec_valid = 0; run(1, 32'h214, 0, 2, 3);
    ldu(7, 0, 7); stl(1, 32'h218, 2, 3);
    br(32'hFFFF_FFFC); run(1, 32'h218, 1, 2, 4);
    run(1, 32'hFFFF_FFFC, 0, 3, 4);
    run(1, 32'h0, 0, 3, 4);
    br(32'h40); a.halt_req = 1; run(1, 32'h4, 1, 3, 4);
    hlt(1, 32'h40, 4, 4);
    br(32'h80); hlt(1, 32'h40, 4, 4);
    hlt(1, 32'h40, 4, 4);
    do_reset();
    ini(3);
    run(3, 32'h0, 0, 0, 0);
    run(3, 32'h4, 0, 0, 0);
    ldu(0, 5, 5); a.halt_req = 1; stl(3, 32'h8, 0, 0);
    a.halt_req = 1; stl(3, 32'h8, 0, 1);
    a.halt_req = 1; stl(3, 32'h8, 0, 2);
    a.halt_req = 1; run(3, 32'h8, 0, 0, 3);
    hlt(3, 32'hC, 0, 3);
    do_reset();
    ini(3);
    br(32'h100); run(3, 32'h0, 1, 0, 0);
    ldu(0, 5, 5); stl(3, 32'h100, 1, 0);
    reset = 1; stl(3, 32'h100, 1, 1);
    reset = 0; ini(3);
    run(3, 32'h0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
